write_back_stage: RTL and testbench

Final pipeline stage of the RISC-V core. It takes one instruction from the memory stage through a valid/ready handshake. It picks the result source (ALU, link address, or load data), aligns and extends load data, and drives the registered `wr_reg`/`reg_write`/`write_back_data` port back into the decode stage's register file. Loads stall the stage until data memory returns read data.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/load_align.sv | 37 +++
 rtl/write_back_stage.sv | 119 +++++++++++
 tb/tb_write_back_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg - shared types and constants for the write-back stage.
//   wb_state_t : write-back FSM states (IDLE, LOAD_WAIT)
//   F3_*       : load funct3 encodings understood by load_align
package riscv_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// load_align - combinational alignment and extension of a load word.
// Ports:
//   rdata  in  XLEN  raw word returned by data memory
//   funct3 in  3     load size/sign encoding
//   offset in  2     byte offset of the load address within the word
//   data   out XLEN  aligned, sign/zero-extended result
// Halfwords are picked by offset[1] only; a misaligned halfword is not
// trapped. Unknown encodings pass the word through unchanged.
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        data     = rdata;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// write_back_stage - final pipeline stage. Accepts one instruction from the
// memory stage, selects ALU / link / load result and writes it back to the
// register file through a registered port. Loads hold the stage in LOAD_WAIT
// until data memory returns read data.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   handshake with the memory stage
//   rd_in, write_back_in, mem_rd_in, link_in, funct3_in,
//   alu_result_in, cnt_val_pl4_in   instruction fields
//   mem_rdata, mem_rvalid data memory read return
//   wr_reg, reg_write, write_back_data  register file write port
//   retire                one-cycle pulse per completed instruction
//   instret               retired-instruction counter
// Configuration macro: WB_INSTRET_EN builds the instret counter; without it
// instret is tied to zero.
module write_back_stage
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          rd_in,
    input  logic                write_back_in,
    input  logic                mem_rd_in,
    input  logic                link_in,
    input  logic [2:0]          funct3_in,
    input  logic [XLEN-1:0]     alu_result_in,
    input  logic [XLEN-1:0]     cnt_val_pl4_in,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_rvalid,
    output logic [4:0]          wr_reg,
    output logic                reg_write,
    output logic [XLEN-1:0]     write_back_data,
    output logic                retire,
    output logic [RETIRE_W-1:0] instret
);

    wb_state_t       state;
    logic [4:0]      ld_rd;
    logic            ld_wb;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_offset;
    logic [XLEN-1:0] ld_data;

    // in_ready is a pure decode of the state register, so it is glitch-free
    // and changes only at clock edges.
    assign in_ready = (state == IDLE);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (mem_rdata),
        .funct3 (ld_funct3),
        .offset (ld_offset),
        .data   (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            wr_reg          <= '0;
            reg_write       <= 1'b0;
            write_back_data <= '0;
            retire          <= 1'b0;
            ld_rd           <= '0;
            ld_wb           <= 1'b0;
            ld_funct3       <= '0;
            ld_offset       <= '0;
        end else begin
            // Pulses default low; wr_reg/write_back_data hold.
            reg_write <= 1'b0;
            retire    <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mem_rd_in) begin
                            ld_rd     <= rd_in;
                            ld_wb     <= write_back_in;
                            ld_funct3 <= funct3_in;
                            ld_offset <= alu_result_in[1:0];
                            state     <= LOAD_WAIT;
                        end else begin
                            wr_reg          <= rd_in;
                            write_back_data <= link_in ? cnt_val_pl4_in : alu_result_in;
                            reg_write       <= write_back_in && (rd_in != 5'd0);
                            retire          <= 1'b1;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        wr_reg          <= ld_rd;
                        write_back_data <= ld_data;
                        reg_write       <= ld_wb && (ld_rd != 5'd0);
                        retire          <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    // Counts the cycles retire was high; wraps naturally at full width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + RETIRE_W'(1);
        end
    end
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rd_in;
    logic        write_back_in;
    logic        mem_rd_in;
    logic        link_in;
    logic [2:0]  funct3_in;
    logic [31:0] alu_result_in;
    logic [31:0] cnt_val_pl4_in;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic [31:0] write_back_data;
    logic        retire;
    logic [63:0] instret;

    int n_assert = 0;
    int n_fail   = 0;

    write_back_stage #(.XLEN(32), .RETIRE_W(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .rd_in           (rd_in),
        .write_back_in   (write_back_in),
        .mem_rd_in       (mem_rd_in),
        .link_in         (link_in),
        .funct3_in       (funct3_in),
        .alu_result_in   (alu_result_in),
        .cnt_val_pl4_in  (cnt_val_pl4_in),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid),
        .wr_reg          (wr_reg),
        .reg_write       (reg_write),
        .write_back_data (write_back_data),
        .retire          (retire),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_instret(input int n);
`ifdef WB_INSTRET_EN
        return 64'(n);
`else
        return 64'(0 * n);
`endif
    endfunction

    // Issue a non-load, check its single-cycle write-back.
    task automatic do_op(input string tag, input logic [4:0] rd, input logic wb,
                         input logic link, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] exp_data, input logic exp_we);
        in_valid = 1'b1; mem_rd_in = 1'b0; rd_in = rd; write_back_in = wb;
        link_in = link; alu_result_in = alu; cnt_val_pl4_in = pc4;
        tick();
        in_valid = 1'b0;
        check({tag, ".reg_write"}, 64'(reg_write), 64'(exp_we));
        check({tag, ".retire"},    64'(retire), 64'd1);
        check({tag, ".wr_reg"},    64'(wr_reg), 64'(rd));
        check({tag, ".data"},      64'(write_back_data), 64'(exp_data));
    endtask

    // Issue a load, wait 'gap' extra cycles before read data, check result.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input int gap,
                           input logic [31:0] exp_data);
        in_valid = 1'b1; mem_rd_in = 1'b1; rd_in = rd; write_back_in = 1'b1;
        link_in = 1'b0; funct3_in = f3; alu_result_in = addr;
        mem_rvalid = 1'b0; mem_rdata = ~rdata;
        tick();
        in_valid = 1'b0; mem_rd_in = 1'b0; rd_in = 5'd0; funct3_in = 3'b111;
        alu_result_in = 32'h0;
        for (int i = 0; i < gap; i++) begin
            check({tag, ".wait_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".wait_we"},    64'(reg_write), 64'd0);
            tick();
        end
        check({tag, ".ready_low"}, 64'(in_ready), 64'd0);
        check({tag, ".retire_low"}, 64'(retire), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        check({tag, ".reg_write"}, 64'(reg_write), 64'd1);
        check({tag, ".retire"},    64'(retire), 64'd1);
        check({tag, ".wr_reg"},    64'(wr_reg), 64'(rd));
        check({tag, ".data"},      64'(write_back_data), 64'(exp_data));
        check({tag, ".ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; rd_in = 5'd3; write_back_in = 1'b1;
        mem_rd_in = 1'b0; link_in = 1'b0; funct3_in = 3'b000;
        alu_result_in = 32'h1234_5678; cnt_val_pl4_in = 32'h0;
        mem_rdata = 32'h0; mem_rvalid = 1'b0;

        // Reset held two cycles with in_valid high: nothing accepted
        tick();
        tick();
        check("rst.wr_reg",    64'(wr_reg), 64'd0);
        check("rst.reg_write", 64'(reg_write), 64'd0);
        check("rst.data",      64'(write_back_data), 64'd0);
        check("rst.retire",    64'(retire), 64'd0);
        check("rst.instret",   instret, 64'd0);
        check("rst.in_ready",  64'(in_ready), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst.reg_write", 64'(reg_write), 64'd0);

        // Three back-to-back ALU ops
        do_op("alu5", 5'd5, 1'b1, 1'b0, 32'h11, 32'h0, 32'h11, 1'b1);
        do_op("alu6", 5'd6, 1'b1, 1'b0, 32'h22, 32'h0, 32'h22, 1'b1);
        do_op("alu7", 5'd7, 1'b1, 1'b0, 32'h33, 32'h0, 32'h33, 1'b1);
        tick();
        check("idle.reg_write", 64'(reg_write), 64'd0);
        check("idle.retire",    64'(retire), 64'd0);
        check("idle.data_hold", 64'(write_back_data), 64'h33);
        check("idle.wr_hold",   64'(wr_reg), 64'd7);
        check("alu.instret",    instret, exp_instret(3));

        // mem_rvalid while IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        check("idle_rvalid.reg_write", 64'(reg_write), 64'd0);
        check("idle_rvalid.retire",    64'(retire), 64'd0);

        // Loads: alignment and extension
        do_load("lb",  3'b000, 32'h0000_1003, 5'd9,  32'h80FF_0000, 1, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_1003, 5'd9,  32'h80FF_0000, 0, 32'h0000_0080);
        do_load("lh",  3'b001, 32'h0000_2002, 5'd10, 32'h8001_1234, 0, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_2002, 5'd10, 32'h8001_1234, 2, 32'h0000_8001);
        do_load("lh_lo_odd", 3'b001, 32'h0000_2001, 5'd11, 32'h8001_F234, 0, 32'hFFFF_F234);
        do_load("lw",  3'b010, 32'h0000_3003, 5'd12, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        do_load("lb1", 3'b000, 32'h0000_3001, 5'd13, 32'h0000_7F00, 0, 32'h0000_007F);

        // JAL to x0 retires without writing; JAL to x1 writes PC+4
        do_op("jal_x0", 5'd0, 1'b1, 1'b1, 32'hDEAD_0000, 32'h104, 32'h104, 1'b0);
        do_op("jal_x1", 5'd1, 1'b1, 1'b1, 32'hDEAD_0000, 32'h104, 32'h104, 1'b1);
        // write_back_in low still retires
        do_op("nowb",   5'd4, 1'b0, 1'b0, 32'h55, 32'h0, 32'h55, 1'b0);
        tick();
        check("seq.instret", instret, exp_instret(13));

        // Reset during LOAD_WAIT drops the load
        in_valid = 1'b1; mem_rd_in = 1'b1; rd_in = 5'd14; write_back_in = 1'b1;
        funct3_in = 3'b010; alu_result_in = 32'h100;
        tick();
        in_valid = 1'b0; mem_rd_in = 1'b0;
        check("rstld.in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rstld.ready_after_rst", 64'(in_ready), 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        check("rstld.reg_write", 64'(reg_write), 64'd0);
        check("rstld.retire",    64'(retire), 64'd0);
        check("rstld.in_ready",  64'(in_ready), 64'd1);
        check("rstld.data",      64'(write_back_data), 64'd0);
        check("rstld.instret",   instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
